// File: rtl/fir_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fir_pkg
// Description : Shared types and default constants for the FIR tap sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package fir_pkg;

  localparam int unsigned DEF_AW    = 6;
  localparam int unsigned DEF_NTAPS = 64;
  localparam int unsigned DEF_PIPE  = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_RUN   = 2'd2,
    ST_DRAIN = 2'd3
  } fir_state_e;

  // Per-tap MAC control flags travelling down the operand pipeline
  typedef struct packed {
    logic en;
    logic clear;
    logic last;
  } mac_ctrl_t;

endpackage
`default_nettype wire

// File: rtl/fir_ctrl_delay.sv
`default_nettype none
// ============================================================================
// Module      : fir_ctrl_delay
// Description : PIPE-deep shift register aligning MAC control flags with the
//               operands emerging from the RAM read + multiplier pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
module fir_ctrl_delay
  import fir_pkg::*;
#(
  parameter int PIPE = DEF_PIPE
) (
  input  logic      clock_i,
  input  logic      reset_ni,
  input  mac_ctrl_t ctrl_i,
  output mac_ctrl_t ctrl_o
);

  generate
    if (PIPE == 0) begin : g_bypass
      assign ctrl_o = ctrl_i;
    end else begin : g_pipe
      mac_ctrl_t stage_q [PIPE];

      // Shift the control bundle one stage per cycle; reset flushes it so an
      // aborted sweep can never emit stray MAC strobes.
      always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
          for (int i = 0; i < PIPE; i++) begin
            stage_q[i] <= '0;
          end
        end else begin
          stage_q[0] <= ctrl_i;
          for (int i = 1; i < PIPE; i++) begin
            stage_q[i] <= stage_q[i-1];
          end
        end
      end

      assign ctrl_o = stage_q[PIPE-1];
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/fir_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : fir_sequencer
// Description : Control sequencer for the 8-channel polyphase FIR bank. Writes
//               each incoming sample into the circular buffer, sweeps all taps
//               driving coefficient/sample addresses and MAC strobes, and
//               flags when the MAC outputs are valid.
// Revision    : 1.0 - initial release
// ============================================================================
module fir_sequencer
  import fir_pkg::*;
#(
  parameter int AW    = DEF_AW,
  parameter int NTAPS = DEF_NTAPS,
  parameter int PIPE  = DEF_PIPE
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          din_enable,
  output logic          busy,
  output logic          overrun,
  output logic          smp_we,
  output logic [AW-1:0] smp_waddr,
  output logic [AW-1:0] smp_raddr,
  output logic [AW-1:0] coeffaddress,
  output logic          mac_clear,
  output logic          mac_en,
  output logic          mac_last,
  output logic          dout_valid
);

  localparam int            DCW    = $clog2(PIPE + 1) + 1;
  localparam logic [AW-1:0] K_LAST = AW'(NTAPS - 1);
  localparam logic [AW-1:0] ONE    = AW'(1);
  localparam logic [DCW-1:0] D_LAST = DCW'(PIPE);
  localparam logic [DCW-1:0] D_ONE  = DCW'(1);

  fir_state_e     state_q, state_d;
  logic [AW-1:0]  wptr_q, wptr_d;
  logic [AW-1:0]  base_q, base_d;
  logic [AW-1:0]  k_q, k_d;
  logic [DCW-1:0] dcnt_q, dcnt_d;
  logic           busy_q, busy_d;
  logic           ovr_q, ovr_d;
  logic           we_q, we_d;
  logic [AW-1:0]  waddr_q, waddr_d;
  logic [AW-1:0]  raddr_q, raddr_d;
  logic [AW-1:0]  coeff_q, coeff_d;
  mac_ctrl_t      tap_q, tap_d;
  mac_ctrl_t      mac_q;
  logic           dv_q;
  logic [AW-1:0]  k_inc;

  assign k_inc = k_q + ONE;

  // Next-state and next-output decode; outputs are computed one cycle ahead so
  // every port comes straight from a flop aligned with the state register.
  always_comb begin
    state_d = state_q;
    wptr_d  = wptr_q;
    base_d  = base_q;
    k_d     = k_q;
    dcnt_d  = dcnt_q;
    we_d    = 1'b0;
    waddr_d = '0;
    raddr_d = '0;
    coeff_d = '0;
    tap_d   = '0;
    ovr_d   = din_enable && (state_q != ST_IDLE);

    case (state_q)
      ST_IDLE: begin
        if (din_enable) begin
          state_d = ST_WRITE;
          we_d    = 1'b1;
          waddr_d = wptr_q;
          base_d  = wptr_q;
          k_d     = '0;
        end
      end
      ST_WRITE: begin
        state_d     = ST_RUN;
        wptr_d      = wptr_q + ONE;
        k_d         = '0;
        coeff_d     = '0;
        raddr_d     = base_q;
        tap_d.en    = 1'b1;
        tap_d.clear = 1'b1;
        tap_d.last  = (K_LAST == '0);
      end
      ST_RUN: begin
        if (k_q == K_LAST) begin
          state_d = ST_DRAIN;
          dcnt_d  = '0;
        end else begin
          k_d        = k_inc;
          coeff_d    = k_inc;
          raddr_d    = base_q - k_inc;
          tap_d.en   = 1'b1;
          tap_d.last = (k_inc == K_LAST);
        end
      end
      ST_DRAIN: begin
        // Hold off until the final product has been accumulated and flagged
        if (dcnt_q == D_LAST) begin
          state_d = ST_IDLE;
        end else begin
          dcnt_d = dcnt_q + D_ONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State, pointer and output registers; reset aborts any sweep in progress.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      wptr_q  <= '0;
      base_q  <= '0;
      k_q     <= '0;
      dcnt_q  <= '0;
      busy_q  <= 1'b0;
      ovr_q   <= 1'b0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      raddr_q <= '0;
      coeff_q <= '0;
      tap_q   <= '0;
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
      base_q  <= base_d;
      k_q     <= k_d;
      dcnt_q  <= dcnt_d;
      busy_q  <= busy_d;
      ovr_q   <= ovr_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      raddr_q <= raddr_d;
      coeff_q <= coeff_d;
      tap_q   <= tap_d;
    end
  end

  fir_ctrl_delay #(
    .PIPE (PIPE)
  ) u_ctrl_delay (
    .clock_i  (clock),
    .reset_ni (reset),
    .ctrl_i   (tap_q),
    .ctrl_o   (mac_q)
  );

  // Results are valid the cycle after the last product enters the MACs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      dv_q <= 1'b0;
    end else begin
      dv_q <= mac_q.last;
    end
  end

  assign busy         = busy_q;
  assign overrun      = ovr_q;
  assign smp_we       = we_q;
  assign smp_waddr    = waddr_q;
  assign smp_raddr    = raddr_q;
  assign coeffaddress = coeff_q;
  assign mac_en       = mac_q.en;
  assign mac_clear    = mac_q.clear;
  assign mac_last     = mac_q.last;
  assign dout_valid   = dv_q;

endmodule
`default_nettype wire

// File: tb/tb_fir_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_fir_sequencer
// Description : Self-checking bench for fir_sequencer against a timeline model
//               derived from sample acceptance times.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fir_sequencer;

  localparam int AW    = 6;
  localparam int NT    = 64;
  localparam int PP    = 2;
  localparam int DEPTH = 1 << AW;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          din_enable = 1'b0;
  logic          busy, overrun, smp_we, mac_clear, mac_en, mac_last, dout_valid;
  logic [AW-1:0] smp_waddr, smp_raddr, coeffaddress;

  always #2 clock = ~clock;

  fir_sequencer #(
    .AW    (AW),
    .NTAPS (NT),
    .PIPE  (PP)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .din_enable   (din_enable),
    .busy         (busy),
    .overrun      (overrun),
    .smp_we       (smp_we),
    .smp_waddr    (smp_waddr),
    .smp_raddr    (smp_raddr),
    .coeffaddress (coeffaddress),
    .mac_clear    (mac_clear),
    .mac_en       (mac_en),
    .mac_last     (mac_last),
    .dout_valid   (dout_valid)
  );

  int nchecks = 0;
  int nfail   = 0;

  // Reference model: a sweep is fully described by its acceptance edge and
  // the write pointer it used; every output follows from the offset to it.
  int e = 0;          // edges since start
  int s = 0;          // edge at which current sweep was accepted
  bit act = 1'b0;     // a sweep has been accepted since reset
  int wcur = 0;       // write address of current sweep
  int wptr = 0;
  bit ovr_exp = 1'b0;
  int dv_seen = 0;
  int dv_exp  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchecks++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s at edge %0d: got=%0d expected=%0d", tag, e, got, exp);
    end
  endtask

  function automatic bit can_accept();
    return !act || ((e + 1 - s) >= NT + PP + 3);
  endfunction

  task automatic check_zero(input string pfx);
    check({pfx, "_busy"},  busy, 0);
    check({pfx, "_ovr"},   overrun, 0);
    check({pfx, "_we"},    smp_we, 0);
    check({pfx, "_waddr"}, smp_waddr, 0);
    check({pfx, "_raddr"}, smp_raddr, 0);
    check({pfx, "_coeff"}, coeffaddress, 0);
    check({pfx, "_clr"},   mac_clear, 0);
    check({pfx, "_en"},    mac_en, 0);
    check({pfx, "_last"},  mac_last, 0);
    check({pfx, "_dv"},    dout_valid, 0);
  endtask

  task automatic check_outputs();
    int rel;
    bit live, run, wr;
    rel  = act ? (e - s + 1) : 0;
    live = act && (rel <= NT + PP + 2);
    wr   = live && (rel == 1);
    run  = live && (rel >= 2) && (rel <= NT + 1);
    check("busy", busy, live);
    check("we", smp_we, wr);
    if (wr) check("waddr", smp_waddr, wcur);
    else begin
      check("coeff", coeffaddress, run ? (rel - 2) : 0);
      check("raddr", smp_raddr, run ? ((wcur - (rel - 2) + DEPTH) % DEPTH) : 0);
    end
    check("mac_en", mac_en, live && (rel >= PP + 2) && (rel <= NT + PP + 1));
    check("mac_clear", mac_clear, live && (rel == PP + 2));
    check("mac_last", mac_last, live && (rel == NT + PP + 1));
    check("dout_valid", dout_valid, live && (rel == NT + PP + 2));
    check("overrun", overrun, ovr_exp);
    if (live && (rel == NT + PP + 2)) dv_exp++;
    if (dout_valid) dv_seen++;
  endtask

  task automatic step(input bit din);
    din_enable = din;
    @(posedge clock);
    e++;
    ovr_exp = 1'b0;
    if (din) begin
      if (!act || ((e - s) >= NT + PP + 3)) begin
        act  = 1'b1;
        s    = e;
        wcur = wptr;
        wptr = (wptr + 1) % DEPTH;
      end else begin
        ovr_exp = 1'b1;
      end
    end
    @(negedge clock);
    check_outputs();
  endtask

  // Advance until the current cycle, relative to the sweep start, equals c
  task automatic run_to(input int c);
    for (int i = 0; i < 200 && (e + 1 - s) < c; i++) step(1'b0);
  endtask

  task automatic do_reset();
    din_enable = 1'b0;
    reset = 1'b0;
    #1;
    check_zero("rst_async");
    act     = 1'b0;
    wptr    = 0;
    ovr_exp = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check_zero("rst_hold");
    reset = 1'b1;
  endtask

  initial begin
    int accepted;
    bit d;
    #1;
    do_reset();
    repeat (3) step(1'b0);

    // First sample after reset, overrun mid-sweep, boundary at 68/69
    step(1'b1);
    run_to(30);
    step(1'b1);
    run_to(68);
    step(1'b1);
    step(1'b1);

    // Abort mid-sweep, then the pointer must restart at 0
    run_to(30);
    do_reset();
    repeat (2) step(1'b0);
    step(1'b1);

    // Back-to-back sweeps with random overrun attempts; wraps write pointer
    accepted = 1;
    for (int n = 0; n < 20000 && accepted < 66; n++) begin
      if (can_accept()) begin
        d = 1'b1;
        accepted++;
      end else begin
        d = ($urandom_range(0, 19) == 0);
      end
      step(d);
    end
    check("accepted_count", accepted, 66);

    // Sparse random traffic
    repeat (300) step($urandom_range(0, 29) == 0);
    for (int i = 0; i < 200 && !can_accept(); i++) step(1'b0);
    repeat (3) step(1'b0);

    check("dv_count", dv_seen, dv_exp);
    $display("TB_RESULT checks=%0d failures=%0d", nchecks, nfail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fir_sequencer.md
# fir_sequencer

Control sequencer for the 8-channel polyphase FIR filter bank (`profir` datapath). On each input-sample strobe it writes the sample into the circular sample buffer, then sweeps all taps. It drives the shared coefficient address, the sample-buffer read address and the MAC control strobes for the 8 parallel MACs, and flags when the 8 outputs are valid. It sits between the sample input and the coefficient memories, sample RAM and MAC array.

## Interface

Parameters:
- `AW`, 6: address width of the coefficient memories and sample buffer; buffer depth 2^AW.
- `NTAPS`, 64: taps per filter; must satisfy NTAPS ≤ 2^AW.
- `PIPE`, 2: cycles from address issue to MAC operand available (RAM read + multiplier register).

Ports:
- `clock` in 1: master 250 MHz clock, rising edge.
- `reset` in 1: master reset, asynchronous, active-low.
- `din_enable` in 1: new sample at `datain`; 1-cycle pulse.
- `busy` out 1: high whenever state ≠ IDLE.
- `overrun` out 1: 1-cycle pulse; `din_enable` arrived while busy, sample dropped.
- `smp_we` out 1: sample-buffer write strobe.
- `smp_waddr` out AW: sample-buffer write address (write pointer).
- `smp_raddr` out AW: sample-buffer read address.
- `coeffaddress` out AW: shared coefficient memory address (tap index).
- `mac_clear` out 1: MAC loads product, discarding accumulator (first tap).
- `mac_en` out 1: MAC accumulates this cycle.
- `mac_last` out 1: final tap product entering MAC.
- `dout_valid` out 1: 1-cycle pulse; `dataout0..7` valid and must be registered by the datapath.

## Operation

- FSM states: IDLE, WRITE, RUN, DRAIN. All outputs registered.
- IDLE: `din_enable`=1 → WRITE. Otherwise stay.
- WRITE (1 cycle): `smp_we`=1, `smp_waddr`=wptr. Latch base=wptr, k=0. wptr increments mod 2^AW on exit → RUN.
- RUN (NTAPS cycles): `coeffaddress`=k, `smp_raddr`=(base−k) mod 2^AW, k increments. At k=NTAPS−1 → DRAIN.
- DRAIN (PIPE+1 cycles): addresses return to 0. Then → IDLE.
- MAC strobes are the RUN-cycle tap-valid flags delayed by PIPE:
  - `mac_en` is the delayed tap-valid.
  - `mac_clear` is the delayed k==0.
  - `mac_last` is the delayed k==NTAPS−1.
  - `dout_valid` = `mac_last` delayed 1 cycle.
- `din_enable` in any state other than IDLE: ignored; `overrun` pulses the next cycle; wptr unchanged.
- Reset: every output is 0; wptr=0, k=0, base=0, state=IDLE, delay line cleared.
- Reset mid-sweep: immediate abort; no `dout_valid` is issued for the aborted sample.
- wptr wraps 2^AW−1 → 0. Read addresses wrap below 0 to 2^AW−1.

## Timing

- Reference point: `din_enable` sampled at edge 0. Values below use NTAPS=64, PIPE=2.
- Cycle 1: WRITE; `smp_we`=1; `busy` rises.
- Cycles 2..65: RUN; `coeffaddress` 0..63.
- Cycle 4: `mac_clear`=1.
- Cycles 4..67: `mac_en`=1.
- Cycle 67: `mac_last`=1.
- Cycle 68: `dout_valid`=1.
- Cycles 66..68: DRAIN.
- Cycle 69: IDLE; `busy`=0.
- General form: `dout_valid` at cycle NTAPS+PIPE+2; next sample accepted at cycle ≥ NTAPS+PIPE+3.
- The sample buffer must return data written in cycle 1 when read in cycle 2 (write-before-read across cycles; no same-cycle bypass needed).

## Structure

- Package `fir_pkg`:
  - state enum (IDLE/WRITE/RUN/DRAIN);
  - default constants AW=6, NTAPS=64, PIPE=2;
  - MAC control bundle typedef {en, clear, last}.
- Sub-module `fir_ctrl_delay`: parameterised PIPE-deep shift register for the MAC control bundle, async active-low clear.
- FSM, tap counter and pointers live in `fir_sequencer`.

## Test plan

- Reset low asserted at cycle 30 of a sweep → all outputs 0 asynchronously; no `dout_valid`; next `din_enable` gives `smp_waddr`=0.
- Single `din_enable` at cycle 0 after reset → `smp_we` at cycle 1 with waddr 0; `smp_raddr` 0,63,62,…,1 over cycles 2..65; `mac_clear` at cycle 4, `mac_last` at 67, `dout_valid` at 68; `busy` high 1..68.
- Second sample → waddr 1; `smp_raddr` 1,0,63,…,2; `coeffaddress` 0..63 again.
- `din_enable` at cycle 30 of a sweep → `overrun` at cycle 31; sweep timing unchanged; wptr not advanced.
- Boundary: `din_enable` at cycle 68 → `overrun`. At cycle 69 → accepted, `smp_we` at cycle 70.
- 65 back-to-back accepted samples → `smp_waddr` wraps 63 → 0; each sweep yields exactly one `dout_valid`.
